// File: rtl/lstm_pkg.sv
// Shared types and helpers for the LSTM timestep sequencer: FSM encoding,
// default data format and the address-width helper.
package lstm_pkg;

    localparam int LSTM_WIDTH = 32;
    localparam int LSTM_FRAC  = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_ACC_X,
        ST_ACC_H,
        ST_WAIT,
        ST_CAPT,
        ST_DONE
    } state_t;

    // Never returns less than 1 so single-entry memories still get a real port.
    function automatic int clog2_min1(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/lstm_seq_ctrl_if.sv
// Bus between the sequencer, the layer buffers and the LSTM cell.
// master = sequencer side, slave = buffers/cell/host side.
interface lstm_seq_ctrl_if
    import lstm_pkg::*;
#(
    parameter int WIDTH = LSTM_WIDTH,
    parameter int NUM_X = 4,
    parameter int NUM_H = 8,
    parameter int T_W   = 16
);
    localparam int XA_W = clog2_min1(NUM_X);
    localparam int HA_W = clog2_min1(NUM_H);

    logic             i_start;
    logic [T_W-1:0]   i_num_steps;
    logic [WIDTH-1:0] i_c;
    logic [WIDTH-1:0] i_h;
    logic             o_acc_x;
    logic             o_acc_h;
    logic [XA_W-1:0]  o_x_addr;
    logic [HA_W-1:0]  o_h_addr;
    logic [T_W-1:0]   o_t;
    logic [WIDTH-1:0] o_prev_state;
    logic [WIDTH-1:0] o_h_out;
    logic             o_h_valid;
    logic             o_busy;
    logic             o_done;

    modport master (
        input  i_start, i_num_steps, i_c, i_h,
        output o_acc_x, o_acc_h, o_x_addr, o_h_addr, o_t,
               o_prev_state, o_h_out, o_h_valid, o_busy, o_done
    );

    modport slave (
        output i_start, i_num_steps, i_c, i_h,
        input  o_acc_x, o_acc_h, o_x_addr, o_h_addr, o_t,
               o_prev_state, o_h_out, o_h_valid, o_busy, o_done
    );

endinterface

// File: rtl/lstm_step_cnt.sv
// Loadable down-counter with terminal flag; times the ACC_X, ACC_H and WAIT phases.
module lstm_step_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         tc
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/lstm_seq_ctrl.sv
// LSTM cell sequencer over T timesteps: CLR, NUM_X x-beats, NUM_H h-beats, activation wait, capture.
// Build option LSTM_SEQ_STATE_CLR_EN: an accepted start also clears the stored c/h state.
//
//  state  | meaning
//  IDLE   | waiting for i_start; T latched on accept
//  CLR    | cell accumulators reload bias; address counters at 0
//  ACC_X  | NUM_X beats with acc_x, x_addr 0..NUM_X-1
//  ACC_H  | NUM_H beats with acc_h, h_addr 0..NUM_H-1
//  WAIT   | ACT_LAT cycles of activation latency
//  CAPT   | capture c(t)/h(t); last step -> DONE, else t++ -> CLR
//  DONE   | one-cycle o_done, then IDLE
module lstm_seq_ctrl
    import lstm_pkg::*;
#(
    parameter int WIDTH   = LSTM_WIDTH,
    parameter int NUM_X   = 4,
    parameter int NUM_H   = 8,
    parameter int ACT_LAT = 2,
    parameter int T_W     = 16
) (
    input logic           clk,
    input logic           rst,
    lstm_seq_ctrl_if.master bus
);
    localparam int XA_W    = clog2_min1(NUM_X);
    localparam int HA_W    = clog2_min1(NUM_H);
    localparam int MAX_LEN = (NUM_X > NUM_H) ? ((NUM_X > ACT_LAT) ? NUM_X : ACT_LAT)
                                             : ((NUM_H > ACT_LAT) ? NUM_H : ACT_LAT);
    localparam int CNT_W   = clog2_min1(MAX_LEN + 1);

    state_t           state_q, state_d;
    logic [T_W-1:0]   t_q, t_d;
    logic [T_W-1:0]   num_q, num_d;
    logic [XA_W-1:0]  x_addr_q, x_addr_d;
    logic [HA_W-1:0]  h_addr_q, h_addr_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] hout_q, hout_d;
    logic             hval_q, hval_d;
    logic             cnt_load, cnt_dec, cnt_tc;
    logic [CNT_W-1:0] cnt_val;

    lstm_step_cnt #(.W(CNT_W)) u_step_cnt (
        .clk      (clk),
        .rst_n    (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .tc       (cnt_tc)
    );

    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        num_d    = num_q;
        x_addr_d = x_addr_q;
        h_addr_d = h_addr_q;
        prev_d   = prev_q;
        hout_d   = hout_q;
        hval_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    num_d   = bus.i_num_steps;
                    t_d     = '0;
`ifdef LSTM_SEQ_STATE_CLR_EN
                    prev_d  = '0;
                    hout_d  = '0;
`endif
                    state_d = (bus.i_num_steps == '0) ? ST_DONE : ST_CLR;
                end
            end
            ST_CLR: begin
                cnt_load = 1'b1;
                cnt_val  = CNT_W'(NUM_X - 1);
                state_d  = ST_ACC_X;
            end
            ST_ACC_X: begin
                if (cnt_tc) begin
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(NUM_H - 1);
                    state_d  = ST_ACC_H;
                end else begin
                    cnt_dec  = 1'b1;
                    x_addr_d = x_addr_q + XA_W'(1);
                end
            end
            ST_ACC_H: begin
                if (cnt_tc) begin
                    if (ACT_LAT == 0) begin
                        state_d = ST_CAPT;
                    end else begin
                        cnt_load = 1'b1;
                        cnt_val  = CNT_W'(ACT_LAT - 1);
                        state_d  = ST_WAIT;
                    end
                end else begin
                    cnt_dec  = 1'b1;
                    h_addr_d = h_addr_q + HA_W'(1);
                end
            end
            ST_WAIT: begin
                if (cnt_tc) state_d = ST_CAPT;
                else        cnt_dec = 1'b1;
            end
            ST_CAPT: begin
                prev_d = bus.i_c;
                hout_d = bus.i_h;
                hval_d = 1'b1;
                if (t_q == num_q - T_W'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    t_d     = t_q + T_W'(1);
                    state_d = ST_CLR;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Addresses read 0 for the whole CLR cycle, so clear them on the way in.
        if (state_d == ST_CLR) begin
            x_addr_d = '0;
            h_addr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            t_q      <= '0;
            num_q    <= '0;
            x_addr_q <= '0;
            h_addr_q <= '0;
            prev_q   <= '0;
            hout_q   <= '0;
            hval_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            num_q    <= num_d;
            x_addr_q <= x_addr_d;
            h_addr_q <= h_addr_d;
            prev_q   <= prev_d;
            hout_q   <= hout_d;
            hval_q   <= hval_d;
        end
    end

    assign bus.o_acc_x      = (state_q == ST_ACC_X);
    assign bus.o_acc_h      = (state_q == ST_ACC_H);
    assign bus.o_x_addr     = x_addr_q;
    assign bus.o_h_addr     = h_addr_q;
    assign bus.o_t          = t_q;
    assign bus.o_prev_state = prev_q;
    assign bus.o_h_out      = hout_q;
    assign bus.o_h_valid    = hval_q;
    assign bus.o_busy       = (state_q != ST_IDLE);
    assign bus.o_done       = (state_q == ST_DONE);

endmodule
